mem_bus_router: RTL
===================

# mem_bus_router

- Sits between the CPU's native memory bus (valid/ready/addr/wdata/wstrb/rdata) and the SoC targets.
- Registers each CPU request, decodes its address and forwards it to the BRAM controller or the UART. LED writes and unmapped accesses are serviced locally.
- Returns read data with a one-cycle `cpu_mem_ready` pulse.
- A per-transaction watchdog keeps a hung target from stalling the CPU forever.

## Interface
- `BRAM_BASE`, default 32'h0000_0000: BRAM window base.
- `BRAM_SIZE`, default 32'h0000_2000: BRAM window size in bytes (8 KB).
- `UART_BASE`, default 32'hF000_0000: UART window base; 8 bytes, data at +0, control at +4.
- `LED_ADDR`, default 32'hF000_1000: LED register address (one word).
- `LED_WIDTH`, default 8: LED register width.
- `TIMEOUT`, default 255: maximum wait cycles for a forwarded access.
- `clk` in 1: system clock; all logic on posedge.
- `reset` in 1: synchronous, active-high; one clock, reset is synchronous and active-high.
- `cpu_mem_valid` in 1: CPU request.
- `cpu_mem_ready` out 1: one-cycle completion pulse.
- `cpu_mem_addr` in 32, `cpu_mem_wdata` in 32, `cpu_mem_wstrb` in 4: request fields. `wstrb == 0` means read.
- `cpu_mem_rdata` out 32: read data, valid while `cpu_mem_ready` is 1.
- `bram_mem_valid` out 1, `bram_mem_ready` in 1, `bram_mem_addr` out 32, `bram_mem_wdata` out 32, `bram_mem_wstrb` out 4, `bram_mem_rdata` in 32: BRAM controller port.
- `uart_mem_*`: same six signals as the BRAM port, for the UART.
- `led` out LED_WIDTH: LED register.
- `bus_error` out 1: sticky flag; set on an unmapped access or a timeout.

## Operation
- States: IDLE, FWD, RESP.
- IDLE with `cpu_mem_valid`=1:
  - Latch addr, wdata and wstrb. Decode from the latched values.
  - BRAM or UART hit: go to FWD. Drive that target's valid from the next cycle with the latched fields. The other target's valid stays 0.
  - LED hit: if `wstrb[0]`, set `led <= wdata[LED_WIDTH-1:0]`. Set `rdata` to the zero-extended `led` value before the write. Go to RESP.
  - Unmapped: writes are ignored, `rdata = 0`, `bus_error <= 1`. Go to RESP.
- FWD: target valid is held with stable fields until that target's ready is seen.
  - On target ready: capture its rdata, drop target valid on the same edge, clear the watchdog, go to RESP.
  - Watchdog: increments every FWD cycle. On reaching TIMEOUT with no ready:
    - drop target valid;
    - `rdata = 32'hDEAD_BEEF`;
    - `bus_error <= 1`;
    - go to RESP.
  - A ready arriving in the same cycle as the timeout wins: normal completion, no error.
- RESP: `cpu_mem_ready = 1` for exactly one cycle with `cpu_mem_rdata`, then go to IDLE.
- The CPU holds its request until ready and drops `valid` on the ready edge. `cpu_mem_valid` is not sampled in RESP, so one request never produces two transactions.
- Decode ranges:
  - BRAM: `BRAM_BASE <= addr < BRAM_BASE + BRAM_SIZE`.
  - UART: `UART_BASE <= addr < UART_BASE + 8`.
  - LED: `addr == LED_ADDR`, after masking `addr[1:0]`.
  - Comparisons are 32-bit unsigned.
- Forwarded addr is passed through unmodified.
- wstrb is forwarded as-is. The BRAM controller honours only 4'b1111, and that is the software's concern.

## Timing
- Reset values: state IDLE; all target valids 0; `cpu_mem_ready` 0; `cpu_mem_rdata` 0; `led` 0; `bus_error` 0; watchdog 0.
- Reset mid-transaction aborts the transaction immediately: no ready pulse, and target valid drops on the reset edge.
- Local access (LED or unmapped): valid sampled at edge N, `cpu_mem_ready` high in cycle N+1. Latency 2 cycles.
- Forwarded access: target valid is high from N+1. If target ready is high in cycle M, `cpu_mem_ready` is high in cycle M+1.
- All outputs are registered; no combinational path from CPU inputs to target outputs.
- The watchdog saturates and is the only arithmetic: `$clog2(TIMEOUT+1)` bits.

## Structure
- Shared package `bus_pkg`:
  - `bus_state_t` enum {IDLE, FWD, RESP};
  - `target_t` enum {TGT_BRAM, TGT_UART, TGT_LED, TGT_NONE};
  - address map constants;
  - `BUS_ERR_DATA` = 32'hDEAD_BEEF.
- One sub-module, `addr_decoder`: purely combinational, 32-bit address in, `target_t` out, parameterised by the map. It is reused by future DMA masters.

## Test plan
- BRAM read at 0x0000_0004 with a stub answering ready 3 cycles after valid:
  - `bram_mem_valid` is held 3 cycles;
  - `cpu_mem_rdata` equals the stub data;
  - `cpu_mem_ready` pulses exactly once, 1 cycle after stub ready.
- UART control read at 0xF000_0004 then data write at 0xF000_0000 with 0x41:
  - the UART stub sees `addr`/`wdata`/`wstrb` unchanged;
  - `bram_mem_valid` stays 0 throughout.
- LED write 0xF000_1000, wdata 0x0000_0037, wstrb 4'b1111: `led` = 8'h37 after completion, read-back returns 0x0000_0037, ready in 2 cycles.
- Unmapped read at 0x8000_0000: rdata 0, ready in 2 cycles, `bus_error` = 1 and stays 1 through later good accesses.
- BRAM stub never answers (TIMEOUT=8): `bram_mem_valid` drops after 8 FWD cycles, rdata 0xDEAD_BEEF, `bus_error` = 1. Repeat with ready in exactly cycle 8: normal data, no error.
- Assert reset during FWD: all valids and `cpu_mem_ready` are 0 the next cycle, `led` = 0, state IDLE, and a following BRAM read completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared types and address-map constants for the CPU memory bus router and
// any future bus masters (e.g. DMA) that need the same address decode.
//   bus_state_t  : router FSM states (IDLE, FWD, RESP)
//   target_t     : decoded target of an address
//   *_DEF        : default address map
//   BUS_ERR_DATA : read data returned when a forwarded access times out
// ---------------------------------------------------------------------------
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        RESP
    } bus_state_t;

    typedef enum logic [1:0] {
        TGT_BRAM,
        TGT_UART,
        TGT_LED,
        TGT_NONE
    } target_t;

    localparam logic [31:0] BRAM_BASE_DEF = 32'h0000_0000;
    localparam logic [31:0] BRAM_SIZE_DEF = 32'h0000_2000;
    localparam logic [31:0] UART_BASE_DEF = 32'hF000_0000;
    localparam logic [31:0] UART_SPAN     = 32'd8;
    localparam logic [31:0] LED_ADDR_DEF  = 32'hF000_1000;
    localparam logic [31:0] BUS_ERR_DATA  = 32'hDEAD_BEEF;

    // Window check written as (addr - base) < size so that a window ending
    // exactly at the top of the 32-bit space does not wrap.
    function automatic logic inWindow(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] size);
        return (addr >= base) && ((addr - base) < size);
    endfunction

endpackage

// File: rtl/addr_decoder.sv
// ---------------------------------------------------------------------------
// addr_decoder
// Purely combinational address decoder for the SoC memory map.
// Ports:
//   i_addr   : 32-bit byte address
//   o_target : which target owns the address (TGT_NONE when unmapped)
// ---------------------------------------------------------------------------
module addr_decoder
    import bus_pkg::*;
#(
    parameter logic [31:0] BRAM_BASE = BRAM_BASE_DEF,
    parameter logic [31:0] BRAM_SIZE = BRAM_SIZE_DEF,
    parameter logic [31:0] UART_BASE = UART_BASE_DEF,
    parameter logic [31:0] LED_ADDR  = LED_ADDR_DEF
) (
    input  logic [31:0] i_addr,
    output target_t     o_target
);

    // Fixed priority decode: BRAM, then UART, then the LED word. The LED
    // register is a single word, so the byte offset bits are ignored.
    always_comb begin
        o_target = TGT_NONE;
        if (inWindow(i_addr, BRAM_BASE, BRAM_SIZE)) begin
            o_target = TGT_BRAM;
        end else if (inWindow(i_addr, UART_BASE, UART_SPAN)) begin
            o_target = TGT_UART;
        end else if ({i_addr[31:2], 2'b00} == LED_ADDR) begin
            o_target = TGT_LED;
        end
    end

endmodule

// File: rtl/mem_bus_router.sv
// ---------------------------------------------------------------------------
// mem_bus_router
// Registers each CPU memory request, decodes it and forwards it to the BRAM
// controller or the UART. LED writes and unmapped accesses are answered
// locally. A per-transaction watchdog bounds how long a target may stall.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   cpu_mem_*             : CPU native bus (valid/ready/addr/wdata/wstrb/rdata)
//   bram_mem_*            : BRAM controller port (router is the master)
//   uart_mem_*            : UART port (router is the master)
//   led                   : LED register
//   bus_error             : sticky error flag (unmapped access or timeout)
// ---------------------------------------------------------------------------
module mem_bus_router
    import bus_pkg::*;
#(
    parameter logic [31:0] BRAM_BASE = BRAM_BASE_DEF,
    parameter logic [31:0] BRAM_SIZE = BRAM_SIZE_DEF,
    parameter logic [31:0] UART_BASE = UART_BASE_DEF,
    parameter logic [31:0] LED_ADDR  = LED_ADDR_DEF,
    parameter int          LED_WIDTH = 8,
    parameter int          TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 cpu_mem_valid,
    output logic                 cpu_mem_ready,
    input  logic [31:0]          cpu_mem_addr,
    input  logic [31:0]          cpu_mem_wdata,
    input  logic [3:0]           cpu_mem_wstrb,
    output logic [31:0]          cpu_mem_rdata,

    output logic                 bram_mem_valid,
    input  logic                 bram_mem_ready,
    output logic [31:0]          bram_mem_addr,
    output logic [31:0]          bram_mem_wdata,
    output logic [3:0]           bram_mem_wstrb,
    input  logic [31:0]          bram_mem_rdata,

    output logic                 uart_mem_valid,
    input  logic                 uart_mem_ready,
    output logic [31:0]          uart_mem_addr,
    output logic [31:0]          uart_mem_wdata,
    output logic [3:0]           uart_mem_wstrb,
    input  logic [31:0]          uart_mem_rdata,

    output logic [LED_WIDTH-1:0] led,
    output logic                 bus_error
);

    localparam int WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    bus_state_t           r_state;
    target_t              r_target;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic [3:0]           r_wstrb;
    logic [WD_W-1:0]      r_wd;
    logic                 r_bramValid;
    logic                 r_uartValid;
    logic                 r_cpuReady;
    logic [31:0]          r_cpuRdata;
    logic [LED_WIDTH-1:0] r_led;
    logic                 r_busError;

    target_t              w_target;
    logic                 w_tgtReady;
    logic [31:0]          w_tgtRdata;
    logic [WD_W-1:0]      w_wdNext;

    // The decoder looks at the incoming address on the same edge that latches
    // it, so the decode result is exactly that of the latched address and the
    // target valid can be registered on that edge.
    addr_decoder #(
        .BRAM_BASE (BRAM_BASE),
        .BRAM_SIZE (BRAM_SIZE),
        .UART_BASE (UART_BASE),
        .LED_ADDR  (LED_ADDR)
    ) u_addr_decoder (
        .i_addr   (cpu_mem_addr),
        .o_target (w_target)
    );

    // Select the handshake of whichever target the current transaction went
    // to, and compute the saturating next watchdog count.
    assign w_tgtReady = (r_target == TGT_BRAM) ? bram_mem_ready : uart_mem_ready;
    assign w_tgtRdata = (r_target == TGT_BRAM) ? bram_mem_rdata : uart_mem_rdata;
    assign w_wdNext   = (r_wd == WD_LIMIT) ? r_wd : r_wd + 1'b1;

    // Main transaction FSM. Every output is a register written here, so no
    // CPU input reaches a target output without passing through a flop.
    // IDLE accepts a request, FWD waits on the target (bounded by the
    // watchdog), RESP gives the CPU its single-cycle ready pulse. A target
    // ready in the timeout cycle is checked first, so it completes normally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_target    <= TGT_NONE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_wd        <= '0;
            r_bramValid <= 1'b0;
            r_uartValid <= 1'b0;
            r_cpuReady  <= 1'b0;
            r_cpuRdata  <= '0;
            r_led       <= '0;
            r_busError  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cpuReady <= 1'b0;
                    if (cpu_mem_valid) begin
                        r_addr   <= cpu_mem_addr;
                        r_wdata  <= cpu_mem_wdata;
                        r_wstrb  <= cpu_mem_wstrb;
                        r_target <= w_target;
                        r_wd     <= '0;
                        case (w_target)
                            TGT_BRAM: begin
                                r_bramValid <= 1'b1;
                                r_state     <= FWD;
                            end
                            TGT_UART: begin
                                r_uartValid <= 1'b1;
                                r_state     <= FWD;
                            end
                            TGT_LED: begin
                                if (cpu_mem_wstrb[0]) begin
                                    r_led <= cpu_mem_wdata[LED_WIDTH-1:0];
                                end
                                r_cpuRdata <= 32'(r_led);
                                r_cpuReady <= 1'b1;
                                r_state    <= RESP;
                            end
                            default: begin
                                r_cpuRdata <= '0;
                                r_busError <= 1'b1;
                                r_cpuReady <= 1'b1;
                                r_state    <= RESP;
                            end
                        endcase
                    end
                end
                FWD: begin
                    if (w_tgtReady) begin
                        r_cpuRdata  <= w_tgtRdata;
                        r_bramValid <= 1'b0;
                        r_uartValid <= 1'b0;
                        r_wd        <= '0;
                        r_cpuReady  <= 1'b1;
                        r_state     <= RESP;
                    end else if (w_wdNext == WD_LIMIT) begin
                        r_cpuRdata  <= BUS_ERR_DATA;
                        r_bramValid <= 1'b0;
                        r_uartValid <= 1'b0;
                        r_wd        <= '0;
                        r_busError  <= 1'b1;
                        r_cpuReady  <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_wd <= w_wdNext;
                    end
                end
                RESP: begin
                    r_cpuReady <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_cpuReady  <= 1'b0;
                    r_bramValid <= 1'b0;
                    r_uartValid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    // Both target ports carry the latched request fields; only the valid of
    // the decoded target is ever raised.
    assign bram_mem_valid = r_bramValid;
    assign bram_mem_addr  = r_addr;
    assign bram_mem_wdata = r_wdata;
    assign bram_mem_wstrb = r_wstrb;

    assign uart_mem_valid = r_uartValid;
    assign uart_mem_addr  = r_addr;
    assign uart_mem_wdata = r_wdata;
    assign uart_mem_wstrb = r_wstrb;

    assign cpu_mem_ready  = r_cpuReady;
    assign cpu_mem_rdata  = r_cpuRdata;
    assign led            = r_led;
    assign bus_error      = r_busError;

endmodule
